// File: rtl/cmos_capture_data.sv
// DVP byte-stream to RGB565 word converter for the OV5640 pixel-clock domain.
// Skips the first frames while the sensor settles, then emits one write strobe per pixel.
module cmos_capture_data #(
  parameter int DATA_WIDTH  = 16,
  parameter int SKIP_FRAMES = 10,
  parameter int H_ACTIVE    = 480,
  parameter int VS_POL      = 1
) (
  input  logic                  cmos_clk,
  input  logic                  cmos_rst_n,
  input  logic                  cmos_vsync,
  input  logic                  cmos_href,
  input  logic [7:0]            cmos_data,
  output logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_data_en,
  output logic                  fifo_data_vs,
  output logic                  frame_valid,
  output logic                  line_err,
  output logic [7:0]            frame_cnt
);

  typedef enum logic [1:0] {SKIP, WAIT, CAPT} state_t;

  localparam logic        VS_ACT     = (VS_POL != 0);
  localparam logic [8:0]  SKIP_LAST  = 9'(SKIP_FRAMES);
  localparam logic [10:0] H_ACT_W    = 11'(H_ACTIVE);
  localparam state_t      RST_STATE  = (SKIP_FRAMES == 0) ? WAIT : SKIP;

  state_t      state, state_nxt;
  logic        vsync_r1, href_r1, href_r2, vs_n_r2;
  logic [7:0]  data_r1;
  logic [1:0]  prime;
  logic        vs_n_r1, vs_rise, vs_fall, href_fall;
  logic [7:0]  skip_cnt;
  logic        phase, line_act;
  logic [7:0]  hi_byte;
  logic [10:0] pix_cnt;
  logic        cap_en, line_bad;

  // Input stage; r1 resets to blanking and edges are held off until r2 holds real sensor data,
  // so a reset released mid-frame never fakes a frame start.
  always_ff @(posedge cmos_clk or negedge cmos_rst_n) begin
    if (!cmos_rst_n) begin
      vsync_r1 <= VS_ACT;
      href_r1  <= 1'b0;
      href_r2  <= 1'b0;
      data_r1  <= 8'd0;
      vs_n_r2  <= 1'b1;
      prime    <= 2'b00;
    end else begin
      vsync_r1 <= cmos_vsync;
      href_r1  <= cmos_href;
      href_r2  <= href_r1;
      data_r1  <= cmos_data;
      vs_n_r2  <= vs_n_r1;
      prime    <= {prime[0], 1'b1};
    end
  end

  assign vs_n_r1   = vsync_r1 ^ ~VS_ACT;
  assign vs_rise   = prime[1] & vs_n_r1 & ~vs_n_r2;
  assign vs_fall   = prime[1] & ~vs_n_r1 & vs_n_r2;
  assign href_fall = href_r2 & ~href_r1;

  always_ff @(posedge cmos_clk or negedge cmos_rst_n) begin
    if (!cmos_rst_n) begin
      state    <= RST_STATE;
      skip_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == SKIP && vs_rise)
        skip_cnt <= skip_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SKIP:    if (vs_rise && ({1'b0, skip_cnt} + 9'd1 == SKIP_LAST)) state_nxt = WAIT;
      WAIT:    if (vs_fall) state_nxt = CAPT;
      CAPT:    state_nxt = CAPT;
      default: state_nxt = RST_STATE;
    endcase
  end

  always_comb begin
    frame_valid = (state == CAPT);
    cap_en      = (state == CAPT) & href_r1 & ~vs_n_r1;
  end

  // A line is judged only if it carried captured bytes, so href in blanking never flags an error.
  assign line_bad = href_fall & line_act & (phase | (pix_cnt != H_ACT_W));

  always_ff @(posedge cmos_clk or negedge cmos_rst_n) begin
    if (!cmos_rst_n) begin
      fifo_data_out <= '0;
      fifo_data_en  <= 1'b0;
      fifo_data_vs  <= 1'b1;
      line_err      <= 1'b0;
      frame_cnt     <= 8'd0;
      phase         <= 1'b0;
      line_act      <= 1'b0;
      hi_byte       <= 8'd0;
      pix_cnt       <= 11'd0;
    end else begin
      fifo_data_en <= 1'b0;
      fifo_data_vs <= ~frame_valid | vs_n_r1;
      if (cap_en) begin
        phase    <= ~phase;
        line_act <= 1'b1;
        if (!phase) begin
          hi_byte <= data_r1;
        end else begin
          fifo_data_out <= {hi_byte, data_r1};
          fifo_data_en  <= 1'b1;
          if (pix_cnt != 11'h7FF)
            pix_cnt <= pix_cnt + 11'd1;
        end
      end else if (!href_r1) begin
        phase <= 1'b0;
      end
      if (href_fall) begin
        pix_cnt  <= 11'd0;
        line_act <= 1'b0;
      end
      if (vs_fall)
        line_err <= 1'b0;
      else if (line_bad)
        line_err <= 1'b1;
      if (vs_rise && state == CAPT)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cmos_capture_data.sv
// Directed bench: two instances (VS_POL=1 and VS_POL=0 with inverted vsync) share one stimulus.
module tb_cmos_capture_data;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs_a, vs_b, href;
  logic [7:0]  data;
  logic [15:0] data_a, data_b;
  logic        en_a, en_b, vsout_a, vsout_b, fv_a, fv_b, le_a, le_b;
  logic [7:0]  fc_a, fc_b;

  int n_cmp = 0, n_fail = 0;
  int str_a = 0, str_b = 0, vslow_a = 0, diff_cnt = 0;
  logic [15:0] last_a = 16'h0;
  int s, v, exp_total;

  assign vs_b = ~vs_a;

  always #5 clk = ~clk;

  cmos_capture_data #(.DATA_WIDTH(16), .SKIP_FRAMES(2), .H_ACTIVE(480), .VS_POL(1)) dut_a (
    .cmos_clk(clk), .cmos_rst_n(rst_n), .cmos_vsync(vs_a), .cmos_href(href), .cmos_data(data),
    .fifo_data_out(data_a), .fifo_data_en(en_a), .fifo_data_vs(vsout_a),
    .frame_valid(fv_a), .line_err(le_a), .frame_cnt(fc_a));

  cmos_capture_data #(.DATA_WIDTH(16), .SKIP_FRAMES(2), .H_ACTIVE(480), .VS_POL(0)) dut_b (
    .cmos_clk(clk), .cmos_rst_n(rst_n), .cmos_vsync(vs_b), .cmos_href(href), .cmos_data(data),
    .fifo_data_out(data_b), .fifo_data_en(en_b), .fifo_data_vs(vsout_b),
    .frame_valid(fv_b), .line_err(le_b), .frame_cnt(fc_b));

  // Running totals sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (en_a) begin
      str_a++;
      last_a = data_a;
    end
    if (en_b) str_b++;
    if (!vsout_a) vslow_a++;
    if (vsout_a !== vsout_b || en_a !== en_b) diff_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk); vs_a = 1'b0; href = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    @(negedge clk); vs_a = 1'b1; href = 1'b0;
    tick(6);
  endtask

  task automatic send_line(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk); href = 1'b1; data = 8'(i);
    end
    @(negedge clk); href = 1'b0;
    tick(6);
  endtask

  task automatic send_frame(input int lines, input int nbytes);
    frame_begin();
    repeat (lines) send_line(nbytes);
    frame_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vs_a = 1'b1; href = 1'b0; data = 8'h00;
    tick(3);
    n_cmp++; if (en_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_en: got %0h want 0", en_a); end
    n_cmp++; if (data_a !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %0h want 0", data_a); end
    n_cmp++; if (vsout_a !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_vs: got %0h want 1", vsout_a); end
    n_cmp++; if (fv_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fv: got %0h want 0", fv_a); end
    n_cmp++; if (le_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_le: got %0h want 0", le_a); end
    n_cmp++; if (fc_a !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_fc: got %0d want 0", fc_a); end
    n_cmp++; if (vsout_b !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_vs_b: got %0h want 1", vsout_b); end
  endtask

  task automatic test_skip_capture();
    @(negedge clk); rst_n = 1'b1;
    tick(5);
    s = str_a; v = vslow_a;
    send_frame(3, 960);
    send_frame(3, 960);
    n_cmp++; if (str_a - s != 0) begin n_fail++; $display("[TB] FAIL skip_strobes: got %0d want 0", str_a - s); end
    n_cmp++; if (vslow_a - v != 0) begin n_fail++; $display("[TB] FAIL skip_vs_low_cycles: got %0d want 0", vslow_a - v); end
    n_cmp++; if (fv_a !== 1'b0) begin n_fail++; $display("[TB] FAIL fv_before_f3: got %0h want 0", fv_a); end
    frame_begin();
    n_cmp++; if (fv_a !== 1'b1) begin n_fail++; $display("[TB] FAIL fv_at_f3: got %0h want 1", fv_a); end
    n_cmp++; if (fv_b !== 1'b1) begin n_fail++; $display("[TB] FAIL fv_b_at_f3: got %0h want 1", fv_b); end
    s = str_a; v = vslow_a;
    repeat (3) send_line(960);
    frame_end();
    n_cmp++; if (str_a - s != 1440) begin n_fail++; $display("[TB] FAIL f3_strobes: got %0d want 1440", str_a - s); end
    n_cmp++; if (!(vslow_a > v)) begin n_fail++; $display("[TB] FAIL f3_vs_low: got %0d low cycles want >0", vslow_a - v); end
    n_cmp++; if (last_a !== 16'hBEBF) begin n_fail++; $display("[TB] FAIL f3_last_pixel: got %h want bebf", last_a); end
    n_cmp++; if (le_a !== 1'b0) begin n_fail++; $display("[TB] FAIL f3_line_err: got %0h want 0", le_a); end
    send_frame(3, 960);
    n_cmp++; if (fc_a !== 8'd2) begin n_fail++; $display("[TB] FAIL f4_frame_cnt: got %0d want 2", fc_a); end
    exp_total = 2880;
  endtask

  task automatic test_pixel();
    frame_begin();
    @(negedge clk); href = 1'b1; data = 8'hF8;
    @(negedge clk); data = 8'h1F;
    @(negedge clk); href = 1'b0; data = 8'h00;
    n_cmp++; if (en_a !== 1'b0) begin n_fail++; $display("[TB] FAIL pix_en_early: got %0h want 0", en_a); end
    @(negedge clk);
    n_cmp++; if (en_a !== 1'b1) begin n_fail++; $display("[TB] FAIL pix_en: got %0h want 1", en_a); end
    n_cmp++; if (data_a !== 16'hF81F) begin n_fail++; $display("[TB] FAIL pix_data: got %h want f81f", data_a); end
    @(negedge clk);
    n_cmp++; if (en_a !== 1'b0) begin n_fail++; $display("[TB] FAIL pix_en_width: got %0h want 0", en_a); end
    n_cmp++; if (data_a !== 16'hF81F) begin n_fail++; $display("[TB] FAIL pix_data_hold: got %h want f81f", data_a); end
    tick(4);
    n_cmp++; if (le_a !== 1'b1) begin n_fail++; $display("[TB] FAIL short_line_err: got %0h want 1", le_a); end
    frame_end();
    exp_total += 1;
  endtask

  task automatic test_odd_line();
    frame_begin();
    n_cmp++; if (le_a !== 1'b0) begin n_fail++; $display("[TB] FAIL le_clear_on_vs_fall: got %0h want 0", le_a); end
    s = str_a;
    send_line(959);
    n_cmp++; if (str_a - s != 479) begin n_fail++; $display("[TB] FAIL odd_strobes: got %0d want 479", str_a - s); end
    n_cmp++; if (last_a !== 16'hBCBD) begin n_fail++; $display("[TB] FAIL odd_last_pixel: got %h want bcbd", last_a); end
    n_cmp++; if (le_a !== 1'b1) begin n_fail++; $display("[TB] FAIL odd_line_err: got %0h want 1", le_a); end
    frame_end();
    n_cmp++; if (le_a !== 1'b1) begin n_fail++; $display("[TB] FAIL le_sticky: got %0h want 1", le_a); end
    frame_begin();
    n_cmp++; if (le_a !== 1'b0) begin n_fail++; $display("[TB] FAIL le_clean_start: got %0h want 0", le_a); end
    send_line(960);
    frame_end();
    n_cmp++; if (le_a !== 1'b0) begin n_fail++; $display("[TB] FAIL le_clean_frame: got %0h want 0", le_a); end
    exp_total += 479 + 480;
  endtask

  task automatic test_blank_href();
    s = str_a;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); href = 1'b1; data = 8'hAA;
    end
    @(negedge clk); href = 1'b0;
    tick(6);
    n_cmp++; if (str_a - s != 0) begin n_fail++; $display("[TB] FAIL blank_strobes: got %0d want 0", str_a - s); end
    n_cmp++; if (le_a !== 1'b0) begin n_fail++; $display("[TB] FAIL blank_line_err: got %0h want 0", le_a); end
    frame_begin();
    s = str_a;
    send_line(960);
    n_cmp++; if (str_a - s != 480) begin n_fail++; $display("[TB] FAIL after_blank_strobes: got %0d want 480", str_a - s); end
    n_cmp++; if (le_a !== 1'b0) begin n_fail++; $display("[TB] FAIL after_blank_le: got %0h want 0", le_a); end
    frame_end();
    exp_total += 480;
  endtask

  task automatic test_wrap();
    n_cmp++; if (fc_a !== 8'd6) begin n_fail++; $display("[TB] FAIL fc_before_wrap: got %0d want 6", fc_a); end
    repeat (249) begin
      @(negedge clk); vs_a = 1'b0;
      tick(3);
      @(negedge clk); vs_a = 1'b1;
      tick(3);
    end
    n_cmp++; if (fc_a !== 8'd255) begin n_fail++; $display("[TB] FAIL fc_255: got %0d want 255", fc_a); end
    @(negedge clk); vs_a = 1'b0;
    tick(3);
    @(negedge clk); vs_a = 1'b1;
    tick(3);
    n_cmp++; if (fc_a !== 8'd0) begin n_fail++; $display("[TB] FAIL fc_wrap: got %0d want 0", fc_a); end
    n_cmp++; if (fc_b !== 8'd0) begin n_fail++; $display("[TB] FAIL fc_b_wrap: got %0d want 0", fc_b); end
  endtask

  task automatic test_reset_midline();
    frame_begin();
    s = str_a;
    for (int i = 0; i < 101; i++) begin
      @(negedge clk); href = 1'b1; data = 8'(i);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (str_a - s != 50) begin n_fail++; $display("[TB] FAIL pre_reset_strobes: got %0d want 50", str_a - s); end
    n_cmp++; if (en_a !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_en: got %0h want 0", en_a); end
    n_cmp++; if (data_a !== 16'h0) begin n_fail++; $display("[TB] FAIL midrst_data: got %h want 0", data_a); end
    n_cmp++; if (vsout_a !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_vs: got %0h want 1", vsout_a); end
    n_cmp++; if (fv_a !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_fv: got %0h want 0", fv_a); end
    n_cmp++; if (fc_a !== 8'd0) begin n_fail++; $display("[TB] FAIL midrst_fc: got %0d want 0", fc_a); end
    @(negedge clk); rst_n = 1'b1;
    s = str_a;
    for (int i = 101; i < 200; i++) begin
      @(negedge clk); href = 1'b1; data = 8'(i);
    end
    @(negedge clk); href = 1'b0;
    tick(6);
    frame_end();
    send_frame(1, 960);
    n_cmp++; if (str_a - s != 0) begin n_fail++; $display("[TB] FAIL reskip_strobes: got %0d want 0", str_a - s); end
    n_cmp++; if (fv_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reskip_fv: got %0h want 0", fv_a); end
    frame_begin();
    n_cmp++; if (fv_a !== 1'b1) begin n_fail++; $display("[TB] FAIL recapture_fv: got %0h want 1", fv_a); end
    s = str_a;
    send_line(960);
    frame_end();
    n_cmp++; if (str_a - s != 480) begin n_fail++; $display("[TB] FAIL recapture_strobes: got %0d want 480", str_a - s); end
    n_cmp++; if (fc_a !== 8'd1) begin n_fail++; $display("[TB] FAIL recapture_fc: got %0d want 1", fc_a); end
    exp_total += 50 + 480;
  endtask

  task automatic test_vs_pol();
    n_cmp++; if (diff_cnt != 0) begin n_fail++; $display("[TB] FAIL pol_waveform_diff: got %0d differing cycles want 0", diff_cnt); end
    n_cmp++; if (str_a != exp_total) begin n_fail++; $display("[TB] FAIL total_strobes_a: got %0d want %0d", str_a, exp_total); end
    n_cmp++; if (str_b != exp_total) begin n_fail++; $display("[TB] FAIL total_strobes_b: got %0d want %0d", str_b, exp_total); end
  endtask

  initial begin
    test_reset();
    test_skip_capture();
    test_pixel();
    test_odd_line();
    test_blank_href();
    test_wrap();
    test_reset_midline();
    test_vs_pol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
